// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader
// Write-side companion to the Rojobot sprite renderer. It takes a valid/ready
// stream of 12-bit pixels and writes them into the sprite RAM write port.
// It uses the renderer's addressing: frame row = orientation, frame column =
// animation step. A command loads either one SPRITE_COLS x SPRITE_ROWS cell
// or the whole 8x3 sheet.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   start, load_all         command strobe; load_all=1 selects the whole sheet
//   frame_row, frame_col    target cell, sampled with start (col 3 is rejected)
//   abort                   terminates an active load; a same-cycle beat is dropped
//   in_data, in_valid       pixel stream (12'h000 = transparent, stored as-is)
//   in_ready                high while loading; decoded from state only
//   wr_en, wr_addr, wr_data registered RAM write port
//   busy                    load in progress
//   done, err               one-cycle pulses: normal completion / rejected start
module sprite_ram_loader #(
  parameter int SPRITE_COLS = 34,
  parameter int SPRITE_ROWS = 34,
  parameter int ADDR_WIDTH  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_all,
  input  logic [2:0]            frame_row,
  input  logic [1:0]            frame_col,
  input  logic                  abort,
  input  logic [11:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [11:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int MEM_COLS       = 3 * SPRITE_COLS;
  localparam int MEM_ROWS       = 8 * SPRITE_ROWS;
  localparam int FRAME_ROW_SIZE = MEM_COLS * SPRITE_ROWS;
  localparam int MEM_SIZE       = MEM_ROWS * MEM_COLS;

  localparam logic [ADDR_WIDTH-1:0] MEM_COLS_A  = ADDR_WIDTH'(MEM_COLS);
  localparam logic [ADDR_WIDTH-1:0] FRAME_ROW_A = ADDR_WIDTH'(FRAME_ROW_SIZE);
  localparam logic [ADDR_WIDTH-1:0] CELL_W_A    = ADDR_WIDTH'(SPRITE_COLS);
  localparam logic [ADDR_WIDTH-1:0] X_LAST      = ADDR_WIDTH'(SPRITE_COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST      = ADDR_WIDTH'(SPRITE_ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_LAST    = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A       = ADDR_WIDTH'(1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                  state_q, state_d;
  logic                    lin_q, lin_d;
  // row_q is the RAM address of pixel (0, y) of the cell being loaded, so the
  // cell address is row_q + x without any multiply in the beat path.
  logic [ADDR_WIDTH-1:0]   row_q, row_d;
  logic [ADDR_WIDTH-1:0]   x_q, x_d;
  logic [ADDR_WIDTH-1:0]   y_q, y_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [11:0]             wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    xfer;
  logic                    last;
  logic                    cmd_ok;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   cell_base;

  always_comb begin
    state_d   = state_q;
    lin_d     = lin_q;
    row_d     = row_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    cell_base = ADDR_WIDTH'(frame_row) * FRAME_ROW_A
              + ADDR_WIDTH'(frame_col) * CELL_W_A;
    cmd_ok    = load_all || (frame_col != 2'd3);
    cur_addr  = lin_q ? cnt_q : (row_q + x_q);
    last      = lin_q ? (cnt_q == MEM_LAST) : ((x_q == X_LAST) && (y_q == Y_LAST));
    // abort kills a beat that coincides with it, so it never reaches the RAM.
    xfer      = (state_q == LOAD) && in_valid && !abort;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd_ok) begin
            state_d = LOAD;
            lin_d   = load_all;
            row_d   = load_all ? '0 : cell_base;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (start) err_d = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cur_addr;
          wr_data_d = in_data;
          cnt_d     = cnt_q + ONE_A;
          if (!lin_q) begin
            if (x_q == X_LAST) begin
              x_d   = '0;
              y_d   = y_q + ONE_A;
              row_d = row_q + MEM_COLS_A;
            end else begin
              x_d = x_q + ONE_A;
            end
          end
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lin_q     <= 1'b0;
      row_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lin_q     <= lin_d;
      row_q     <= row_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Testbench for sprite_ram_loader: a fixed vector table for short command
// sequences, then long cell/sheet loads checked cycle by cycle against a
// reference model that derives each beat's address from its index.
module tb_sprite_ram_loader;

  localparam int SC       = 34;
  localparam int SR       = 34;
  localparam int MC       = 3 * SC;
  localparam int FRS      = MC * SR;
  localparam int MEM_SIZE = 8 * SR * MC;
  localparam int CELL     = SC * SR;

  logic        clk;
  logic        reset;
  logic        start;
  logic        load_all;
  logic [2:0]  frame_row;
  logic [1:0]  frame_col;
  logic        abort;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  sprite_ram_loader #(.SPRITE_COLS(SC), .SPRITE_ROWS(SR), .ADDR_WIDTH(15)) dut (
    .clk(clk), .reset(reset), .start(start), .load_all(load_all),
    .frame_row(frame_row), .frame_col(frame_col), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec;
  int nerr;
  int wcount;
  int dcount;
  int last_addr;

  // Reference model state: an active flag, the mode, the cell base and the
  // index of the next beat. Addresses come from the index by plain arithmetic.
  bit m_busy;
  bit m_lin;
  int m_base;
  int m_k;

  typedef struct {
    bit st; bit la; int row; int col; bit ab; bit vl; int d;
    bit e_en; int e_addr; int e_data; bit e_done; bit e_err; bit e_busy;
  } vec_t;
  vec_t tbl[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int beat_addr(input bit lin, input int base, input int k);
    if (lin) return k;
    return base + (k / SC) * MC + (k % SC);
  endfunction

  task automatic drive(input bit st, input bit la, input int row, input int col,
                       input bit ab, input bit vl, input int d);
    start     = st;
    load_all  = la;
    frame_row = 3'(row);
    frame_col = 2'(col);
    abort     = ab;
    in_valid  = vl;
    in_data   = 12'(d);
  endtask

  task automatic reset_chk(input bit vl);
    drive(0, 0, 0, 0, 0, vl, 12'h5A5);
    reset = 1'b1;
    tick();
    nvec++;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    reset  = 1'b0;
    m_busy = 0;
    m_lin  = 0;
    m_base = 0;
    m_k    = 0;
  endtask

  // One clock: apply inputs, advance the model, compare all outputs.
  task automatic cyc(input bit st, input bit la, input int row, input int col,
                     input bit ab, input bit vl, input int d);
    bit xfer, lastb, e_err, e_done, nb;
    int e_addr, total;
    drive(st, la, row, col, ab, vl, d);
    chk("in_ready_pre", in_ready, m_busy);
    total  = m_lin ? MEM_SIZE : CELL;
    e_err  = st && (m_busy || (!la && col == 3));
    xfer   = m_busy && vl && !ab;
    lastb  = 0;
    e_addr = 0;
    if (xfer) begin
      e_addr = beat_addr(m_lin, m_base, m_k);
      lastb  = (m_k == total - 1);
      m_k++;
    end
    e_done = xfer && lastb;
    nb = m_busy;
    if (m_busy && (ab || e_done)) nb = 0;
    if (!m_busy && st && (la || col != 3)) begin
      nb     = 1;
      m_lin  = la;
      m_base = la ? 0 : row * FRS + col * SC;
      m_k    = 0;
    end
    m_busy = nb;
    tick();
    nvec++;
    chk("wr_en", wr_en, xfer);
    if (xfer) begin
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, d & 12'hFFF);
    end
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("busy", busy, m_busy);
    if (wr_en) begin
      wcount++;
      last_addr = wr_addr;
    end
    if (done) dcount++;
  endtask

  // Feed beats with ~30% idle cycles until the model says the load ended.
  task automatic run_load(input int bound, input string nm);
    int n;
    n = 0;
    while (m_busy && n < bound) begin
      cyc(0, 0, 0, 0, 0, ($urandom_range(0, 99) >= 30), $urandom);
      n++;
    end
    if (m_busy) begin
      nerr++;
      $display("FAIL %s: load still active after %0d cycles, expected completion", nm, bound);
      reset_chk(0);
    end
  endtask

  task automatic clr_counts();
    wcount = 0;
    dcount = 0;
    last_addr = -1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    clr_counts();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset_chk(0);

    // st la row col ab vl data | en addr data done err busy
    tbl[0]  = '{1, 0, 0, 3, 0, 0, 'h000,  0, 0,     'h000, 0, 1, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 'h111,  0, 0,     'h000, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 'h000,  0, 0,     'h000, 0, 0, 0};
    tbl[3]  = '{1, 0, 3, 1, 0, 0, 'h000,  0, 0,     'h000, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 'hABC,  1, 10438, 'hABC, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 'h999,  0, 0,     'h000, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 'h000,  1, 10439, 'h000, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 0, 0, 1, 'h123,  1, 10440, 'h123, 0, 1, 1};
    tbl[8]  = '{0, 0, 0, 0, 1, 1, 'h555,  0, 0,     'h000, 0, 0, 0};
    tbl[9]  = '{1, 0, 7, 2, 0, 0, 'h000,  0, 0,     'h000, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 'hFFF,  1, 24344, 'hFFF, 0, 0, 1};
    tbl[11] = '{1, 0, 1, 1, 1, 1, 'h321,  0, 0,     'h000, 0, 1, 0};
    tbl[12] = '{1, 1, 0, 0, 1, 0, 'h000,  0, 0,     'h000, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 'h007,  1, 0,     'h007, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 1, 0, 'h000,  0, 0,     'h000, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].st, tbl[i].la, tbl[i].row, tbl[i].col, tbl[i].ab, tbl[i].vl, tbl[i].d);
      tick();
      nvec++;
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].e_en);
      if (tbl[i].e_en) begin
        chk($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].e_data);
      end
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_busy);
    end
    reset_chk(0);

    // Cell (0,0), in_valid held high, data = beat index.
    clr_counts();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < CELL; i++) cyc(0, 0, 0, 0, 0, 1, i);
    chk("cell00_writes", wcount, CELL);
    chk("cell00_dones", dcount, 1);
    chk("cell00_last_addr", last_addr, 3399);

    // Cell (7,2) with gaps; a back-to-back start right after done.
    clr_counts();
    cyc(1, 0, 7, 2, 0, 0, 0);
    run_load(3000, "cell72");
    chk("cell72_writes", wcount, CELL);
    chk("cell72_last_addr", last_addr, 27743);
    clr_counts();
    cyc(1, 0, 3, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 'h0AA);
    chk("cell31_first_addr", last_addr, 10438);
    run_load(3000, "cell31");
    chk("cell31_writes", wcount, CELL);

    // Whole sheet with random gaps.
    clr_counts();
    cyc(1, 1, 0, 0, 0, 0, 0);
    run_load(45000, "sheet");
    chk("sheet_writes", wcount, MEM_SIZE);
    chk("sheet_dones", dcount, 1);
    chk("sheet_last_addr", last_addr, MEM_SIZE - 1);

    // Rejected command: frame_col == 3.
    clr_counts();
    cyc(1, 0, 2, 3, 0, 1, 'h444);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, i);
    chk("col3_writes", wcount, 0);

    // start during a load at beat 500 is rejected; load runs to completion.
    clr_counts();
    cyc(1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < CELL; i++) cyc(i == 500, 1, 0, 0, 0, 1, $urandom);
    chk("midstart_writes", wcount, CELL);
    chk("midstart_dones", dcount, 1);

    // abort at beat 600 with in_valid high.
    clr_counts();
    cyc(1, 0, 2, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) cyc(0, 0, 0, 0, 0, 1, i);
    cyc(0, 0, 0, 0, 1, 1, 600);
    chk("abort_writes", wcount, 600);
    chk("abort_dones", dcount, 0);
    chk("abort_last_addr", last_addr, 8691);
    clr_counts();
    cyc(1, 0, 5, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 'h3C3);
    chk("after_abort_first_addr", last_addr, 17408);
    run_load(3000, "after_abort");
    chk("after_abort_writes", wcount, CELL);

    // reset at beat 100, then stray in_valid without a start.
    cyc(1, 0, 4, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 0, 0, 1, i);
    reset_chk(1);
    clr_counts();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 1, $urandom);
    chk("post_reset_writes", wcount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
